rvc_fetch_aligner: RTL and testbench

- Sits between the instruction-fetch word stream and decode.
- Accepts word-aligned 32-bit fetch words and splits them into a halfword queue.
- Realigns 32-bit instructions that straddle word boundaries, expands RV32C instructions to their 32-bit equivalents, and presents one instruction per cycle on a registered valid/ready output.
- Generalises the existing combinational C.LW/C.SW expander: wider C subset, sequential realignment, redirect handling and backpressure.

---
 rtl/rvc_fetch_aligner.sv | 216 +++++++++++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: splits 32-bit fetch words into halfwords, realigns
// straddling 32-bit instructions and expands RV32C to 32-bit encodings.
module rvc_fetch_aligner #(
    parameter int                  PC_WIDTH = 32,
    parameter bit                  ENABLE_C = 1'b1,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid,
    output logic                fetch_ready,
    input  logic [31:0]         fetch_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst_data,
    output logic [PC_WIDTH-1:0] inst_pc,
    output logic                inst_compressed,
    output logic                inst_illegal
);

    logic [15:0]         q0, q1, q2;
    logic [1:0]          count;
    logic [PC_WIDTH-1:0] head_pc;
    logic                skip_low;

    logic                advance;
    logic                head_c;
    logic                emit16;
    logic                emit32;
    logic                accept;
    logic [1:0]          consume;
    logic [1:0]          remain;
    logic [1:0]          add;
    logic [15:0]         lo;
    logic [15:0]         n0, n1, n2;
    logic [1:0]          ncount;
    logic [PC_WIDTH-1:0] pc_inc;

    logic [31:0]         exp_data;
    logic                exp_ill;

    assign pc_inc = PC_WIDTH'({consume, 1'b0});

    // Emit decision, halfwords consumed and fetch acceptance this cycle
    always_comb begin
        advance     = !inst_valid || inst_ready;
        head_c      = q0[1:0] != 2'b11;
        emit16      = advance && (count != 2'd0) && head_c;
        emit32      = advance && !emit16 && (count >= 2'd2);
        consume     = emit16 ? 2'd1 : (emit32 ? 2'd2 : 2'd0);
        remain      = count - consume;
        fetch_ready = !redirect_valid && (remain <= 2'd1);
        accept      = fetch_valid && fetch_ready;
    end

    // Shift out consumed halfwords, then append the accepted word
    always_comb begin
        lo  = skip_low ? fetch_data[31:16] : fetch_data[15:0];
        add = !accept ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
        n0  = q0;
        n1  = q1;
        n2  = q2;
        case (consume)
            2'd1: begin
                n0 = q1;
                n1 = q2;
            end
            2'd2: n0 = q2;
            default: ;
        endcase
        if (accept) begin
            if (remain == 2'd0) begin
                n0 = lo;
                n1 = fetch_data[31:16];
            end else begin
                n1 = lo;
                n2 = fetch_data[31:16];
            end
        end
        ncount = remain + add;
    end

    logic [15:0] h;
    logic [2:0]  rdp, rs1p;
    logic [4:0]  rd, rs2;
    logic [11:0] imm6, lw_off, nzu, lwsp_off, swsp_off;
    logic [20:0] j_off;
    logic [12:0] b_off;

    assign h        = q0;
    assign rdp      = h[4:2];
    assign rs1p     = h[9:7];
    assign rd       = h[11:7];
    assign rs2      = h[6:2];
    assign imm6     = {{6{h[12]}}, h[12], h[6:2]};
    assign lw_off   = {5'b0, h[5], h[12:10], h[6], 2'b00};
    assign nzu      = {2'b0, h[10:7], h[12:11], h[5], h[6], 2'b00};
    assign lwsp_off = {4'b0, h[3:2], h[12], h[6:4], 2'b00};
    assign swsp_off = {4'b0, h[8:7], h[12:9], 2'b00};
    assign j_off    = {{10{h[12]}}, h[8], h[10:9], h[6], h[7],
                       h[2], h[11], h[5:3], 1'b0};
    assign b_off    = {{5{h[12]}}, h[6:5], h[2], h[11:10], h[4:3], 1'b0};

    // Expand the head halfword into its 32-bit equivalent
    always_comb begin
        exp_data = 32'h0;
        exp_ill  = 1'b0;
        case ({h[1:0], h[15:13]})
            5'b00_000: begin
                exp_ill  = nzu == 12'h0;
                exp_data = {nzu, 5'd2, 3'b000, 2'b01, rdp, 7'h13};
            end
            5'b00_010:
                exp_data = {lw_off, 2'b01, rs1p, 3'b010,
                            2'b01, rdp, 7'h03};
            5'b00_110:
                exp_data = {lw_off[11:5], 2'b01, rdp, 2'b01, rs1p,
                            3'b010, lw_off[4:0], 7'h23};
            5'b01_000:
                exp_data = (rd == 5'd0) ? 32'h0000_0013
                         : {imm6, rd, 3'b000, rd, 7'h13};
            5'b01_010:
                exp_data = {imm6, 5'd0, 3'b000, rd, 7'h13};
            5'b01_101:
                exp_data = {j_off[20], j_off[10:1], j_off[11],
                            j_off[19:12], 5'd0, 7'h6f};
            5'b01_110, 5'b01_111:
                exp_data = {b_off[12], b_off[10:5], 5'd0, 2'b01, rs1p,
                            2'b00, h[13], b_off[4:1], b_off[11], 7'h63};
            5'b10_010: begin
                exp_ill  = rd == 5'd0;
                exp_data = {lwsp_off, 5'd2, 3'b010, rd, 7'h03};
            end
            5'b10_110:
                exp_data = {swsp_off[11:5], rs2, 5'd2, 3'b010,
                            swsp_off[4:0], 7'h23};
            5'b10_100: begin
                if (!h[12]) begin
                    if (rs2 == 5'd0) begin
                        exp_ill  = rd == 5'd0;
                        exp_data = {12'h0, rd, 3'b000, 5'd0, 7'h67};
                    end else begin
                        exp_data = {7'h0, rs2, 5'd0, 3'b000, rd, 7'h33};
                    end
                end else begin
                    exp_ill  = rs2 == 5'd0;
                    exp_data = {7'h0, rs2, rd, 3'b000, rd, 7'h33};
                end
            end
            default: exp_ill = 1'b1;
        endcase
        if (!ENABLE_C) begin
            exp_ill = 1'b1;
        end
        if (exp_ill) begin
            exp_data = 32'h0;
        end
    end

    // Halfword queue, head PC and skip_low bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            q0       <= 16'h0;
            q1       <= 16'h0;
            q2       <= 16'h0;
            count    <= 2'd0;
            head_pc  <= RESET_PC;
            skip_low <= 1'b0;
        end else if (redirect_valid) begin
            count    <= 2'd0;
            head_pc  <= {redirect_pc[PC_WIDTH-1:1], 1'b0};
            skip_low <= redirect_pc[1];
        end else begin
            q0      <= n0;
            q1      <= n1;
            q2      <= n2;
            count   <= ncount;
            head_pc <= head_pc + pc_inc;
            if (accept) begin
                skip_low <= 1'b0;
            end
        end
    end

    // Registered instruction output, held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid      <= 1'b0;
            inst_data       <= 32'h0;
            inst_pc         <= '0;
            inst_compressed <= 1'b0;
            inst_illegal    <= 1'b0;
        end else if (redirect_valid) begin
            inst_valid <= 1'b0;
        end else if (advance) begin
            if (emit16) begin
                inst_valid      <= 1'b1;
                inst_data       <= exp_data;
                inst_pc         <= head_pc;
                inst_compressed <= 1'b1;
                inst_illegal    <= exp_ill;
            end else if (emit32) begin
                inst_valid      <= 1'b1;
                inst_data       <= {q1, q0};
                inst_pc         <= head_pc;
                inst_compressed <= 1'b0;
                inst_illegal    <= 1'b0;
            end else begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: directed and randomized checks of the aligner
// against a halfword-stream reference model.
module tb_rvc_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_compressed;
    logic        inst_illegal;

    logic        fr2, iv2, ic2, ii2;
    logic [31:0] id2, ipc2;

    always #5 clk = ~clk;

    rvc_fetch_aligner #(
        .PC_WIDTH(32), .ENABLE_C(1'b1), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_compressed(inst_compressed), .inst_illegal(inst_illegal)
    );

    rvc_fetch_aligner #(
        .PC_WIDTH(32), .ENABLE_C(1'b0), .RESET_PC(32'h0)
    ) dut_noc (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fr2),
        .fetch_data(fetch_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(iv2), .inst_ready(inst_ready),
        .inst_data(id2), .inst_pc(ipc2),
        .inst_compressed(ic2), .inst_illegal(ii2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        c;
        logic        ill;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] feedq[$];
    logic [15:0] mem[0:1023];

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] d,
                                input logic c, input logic ill);
        exp_t e;
        e.pc = pc; e.data = d; e.c = c; e.ill = ill;
        return e;
    endfunction

    // instruction-format encoders
    function automatic logic [31:0] i_t(int imm, int rs1, int f3,
                                        int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] s_t(int imm, int rs2, int rs1,
                                        int f3, int op);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] b_t(int imm, int rs1, int f3);
        return {imm[12], imm[10:5], 5'd0, rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6f};
    endfunction
    function automatic logic [31:0] r_t(int rs2, int rs1, int rd);
        return {7'd0, rs2[4:0], rs1[4:0], 3'd0, rd[4:0], 7'h33};
    endfunction

    function automatic int bt(int h, int i);
        return (h >> i) & 1;
    endfunction

    // Reference expansion: returns {illegal, data}
    function automatic logic [32:0] ref_expand(input logic [15:0] hw);
        int h, q, f3, rdp, rs1p, rd, rs2, imm6, off;
        h = int'(hw);
        q = h & 3; f3 = (h >> 13) & 7;
        rdp = 8 + ((h >> 2) & 7); rs1p = 8 + ((h >> 7) & 7);
        rd = (h >> 7) & 31; rs2 = (h >> 2) & 31;
        imm6 = ((h >> 2) & 31) + bt(h, 12) * 32;
        if (bt(h, 12) == 1) imm6 -= 64;
        off = bt(h, 5) * 64 + ((h >> 10) & 7) * 8 + bt(h, 6) * 4;
        if (q == 0 && f3 == 0) begin
            off = ((h >> 7) & 15) * 64 + ((h >> 11) & 3) * 16
                + bt(h, 5) * 8 + bt(h, 6) * 4;
            if (off == 0) return {1'b1, 32'h0};
            return {1'b0, i_t(off, 2, 0, rdp, 'h13)};
        end
        if (q == 0 && f3 == 2) return {1'b0, i_t(off, rs1p, 2, rdp, 3)};
        if (q == 0 && f3 == 6) return {1'b0, s_t(off, rdp, rs1p, 2, 'h23)};
        if (q == 1 && f3 == 0) begin
            if (rd == 0) return {1'b0, 32'h13};
            return {1'b0, i_t(imm6, rd, 0, rd, 'h13)};
        end
        if (q == 1 && f3 == 2) return {1'b0, i_t(imm6, 0, 0, rd, 'h13)};
        if (q == 1 && f3 == 5) begin
            off = bt(h, 12) * 2048 + bt(h, 8) * 1024
                + ((h >> 9) & 3) * 256 + bt(h, 6) * 128 + bt(h, 7) * 64
                + bt(h, 2) * 32 + bt(h, 11) * 16 + ((h >> 3) & 7) * 2;
            if (bt(h, 12) == 1) off -= 4096;
            return {1'b0, j_t(off)};
        end
        if (q == 1 && f3 >= 6) begin
            off = bt(h, 12) * 256 + ((h >> 5) & 3) * 64 + bt(h, 2) * 32
                + ((h >> 10) & 3) * 8 + ((h >> 3) & 3) * 2;
            if (bt(h, 12) == 1) off -= 512;
            return {1'b0, b_t(off, rs1p, f3 - 6)};
        end
        if (q == 2 && f3 == 2) begin
            off = ((h >> 2) & 3) * 64 + bt(h, 12) * 32 + ((h >> 4) & 7) * 4;
            if (rd == 0) return {1'b1, 32'h0};
            return {1'b0, i_t(off, 2, 2, rd, 3)};
        end
        if (q == 2 && f3 == 6) begin
            off = ((h >> 7) & 3) * 64 + ((h >> 9) & 15) * 4;
            return {1'b0, s_t(off, rs2, 2, 2, 'h23)};
        end
        if (q == 2 && f3 == 4) begin
            if (bt(h, 12) == 0) begin
                if (rs2 == 0) begin
                    if (rd == 0) return {1'b1, 32'h0};
                    return {1'b0, i_t(0, rd, 0, 0, 'h67)};
                end
                return {1'b0, r_t(rs2, 0, rd)};
            end
            if (rs2 == 0) return {1'b1, 32'h0};
            return {1'b0, r_t(rs2, rd, rd)};
        end
        return {1'b1, 32'h0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_valid = 1'b0;
        fetch_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Drive feedq into the DUT and score handshakes against expq
    task automatic run(input int maxc, input int rdy_pct, input int fv_pct);
        int   n;
        exp_t e;
        n = 0;
        while (expq.size() > 0 && n < maxc) begin
            redirect_valid = 1'b0;
            fetch_valid = (feedq.size() > 0) &&
                          ($urandom_range(99) < fv_pct);
            fetch_data = (feedq.size() > 0) ? feedq[0] : $urandom;
            inst_ready = $urandom_range(99) < rdy_pct;
            #1;
            if (inst_valid && inst_ready) begin
                e = expq.pop_front();
                chk("pc", inst_pc, e.pc);
                chk("data", inst_data, e.data);
                chk("comp", 32'(inst_compressed), 32'(e.c));
                chk("ill", 32'(inst_illegal), 32'(e.ill));
            end
            if (fetch_valid && fetch_ready) void'(feedq.pop_front());
            cyc();
            n++;
        end
        if (expq.size() > 0) begin
            chk("timeout_left", 32'(expq.size()), 32'd0);
            expq.delete();
        end
        feedq.delete();
        fetch_valid = 1'b0;
        inst_ready = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        fetch_valid = 1'b1;
        fetch_data = $urandom;
        inst_ready = 1'b0;
        #1;
        chk("redir_fr", 32'(fetch_ready), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        fetch_valid = 1'b0;
        chk("redir_iv", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        logic [32:0] r;
        int          hp, endhw, w0;
        logic [15:0] hw;

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        // reset values
        do_reset();
        #1;
        chk("rst_iv", 32'(inst_valid), 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_c", 32'(inst_compressed), 32'd0);
        chk("rst_ill", 32'(inst_illegal), 32'd0);
        chk("rst_fr", 32'(fetch_ready), 32'd1);

        // single word: C.LW then illegal 0x0000; ENABLE_C=0 copy
        fetch_valid = 1'b1;
        fetch_data = 32'h0000_40C0;
        cyc();
        fetch_valid = 1'b0;
        cyc();
        chk("t1_iv", 32'(inst_valid), 32'd1);
        chk("t1_data", inst_data, 32'h0044_A403);
        chk("t1_pc", inst_pc, 32'h100);
        chk("t1_c", 32'(inst_compressed), 32'd1);
        chk("noc_iv", 32'(iv2), 32'd1);
        chk("noc_ill", 32'(ii2), 32'd1);
        chk("noc_data", id2, 32'd0);
        chk("noc_pc", ipc2, 32'd0);
        inst_ready = 1'b1;
        cyc();
        chk("t1b_ill", 32'(inst_illegal), 32'd1);
        chk("t1b_data", inst_data, 32'd0);
        chk("t1b_pc", inst_pc, 32'h102);
        cyc();
        chk("t1_drain", 32'(inst_valid), 32'd0);

        // straddling 32-bit instruction
        do_reset();
        feedq = '{32'h0093_40C0, 32'h0001_0010};
        expq.push_back(mk(32'h100, 32'h0044_A403, 1'b1, 1'b0));
        expq.push_back(mk(32'h102, 32'h0010_0093, 1'b0, 1'b0));
        expq.push_back(mk(32'h106, 32'h0000_0013, 1'b1, 1'b0));
        run(100, 100, 100);

        // redirect to odd halfword
        redirect_to(32'h202);
        feedq = '{32'h4501_FFFF};
        expq.push_back(mk(32'h202, 32'h0000_0513, 1'b1, 1'b0));
        run(100, 100, 100);
        inst_ready = 1'b1;
        cyc();
        cyc();
        chk("redir_drain", 32'(inst_valid), 32'd0);

        // aligned 32-bit stream, one per cycle
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_valid = i < 4;
            fetch_data = 32'h0010_0093;
            #1;
            if (i < 4) chk("stream_fr", 32'(fetch_ready), 32'd1);
            if (i >= 2) begin
                chk("stream_iv", 32'(inst_valid), 32'd1);
                chk("stream_pc", inst_pc, 32'h100 + 32'(4 * (i - 2)));
                chk("stream_data", inst_data, 32'h0010_0093);
            end
            cyc();
        end
        fetch_valid = 1'b0;

        // backpressure with four compressed instructions queued
        do_reset();
        inst_ready = 1'b0;
        fetch_valid = 1'b1;
        fetch_data = 32'h4501_40C0;
        #1;
        chk("bp_fr0", 32'(fetch_ready), 32'd1);
        cyc();
        fetch_data = 32'h0505_0001;
        #1;
        chk("bp_fr1", 32'(fetch_ready), 32'd1);
        cyc();
        fetch_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_hold_fr", 32'(fetch_ready), 32'd0);
            chk("bp_hold_iv", 32'(inst_valid), 32'd1);
            chk("bp_hold_data", inst_data, 32'h0044_A403);
            chk("bp_hold_pc", inst_pc, 32'h100);
            cyc();
        end
        fetch_valid = 1'b0;
        expq.push_back(mk(32'h100, 32'h0044_A403, 1'b1, 1'b0));
        expq.push_back(mk(32'h102, 32'h0000_0513, 1'b1, 1'b0));
        expq.push_back(mk(32'h104, 32'h0000_0013, 1'b1, 1'b0));
        expq.push_back(mk(32'h106, 32'h0015_0513, 1'b1, 1'b0));
        run(100, 100, 100);

        // redirect while output valid and fetch offered
        do_reset();
        fetch_valid = 1'b1;
        fetch_data = 32'h0010_0093;
        cyc();
        cyc();
        chk("redir_pre_iv", 32'(inst_valid), 32'd1);
        redirect_to(32'h40);

        // reset mid-stream
        do_reset();
        fetch_valid = 1'b1;
        fetch_data = 32'h0010_0093;
        cyc();
        cyc();
        chk("mid_pre_iv", 32'(inst_valid), 32'd1);
        rst = 1'b1;
        cyc();
        chk("mid_iv", 32'(inst_valid), 32'd0);
        chk("mid_data", inst_data, 32'd0);
        chk("mid_pc", inst_pc, 32'd0);
        chk("mid_c", 32'(inst_compressed), 32'd0);
        chk("mid_ill", 32'(inst_illegal), 32'd0);
        chk("mid_fr", 32'(fetch_ready), 32'd1);
        rst = 1'b0;
        fetch_valid = 1'b0;

        // randomized phases, each started by a redirect
        for (int p = 0; p < 40; p++) begin
            hp = $urandom_range(400);
            redirect_to(32'(hp * 2) | 32'($urandom_range(1)));
            w0 = hp / 2;
            for (int w = 0; w < 24; w++)
                feedq.push_back({mem[2 * (w0 + w) + 1], mem[2 * (w0 + w)]});
            endhw = 2 * (w0 + 24);
            while (1) begin
                hw = mem[hp];
                if (hw[1:0] != 2'b11) begin
                    if (hp >= endhw) break;
                    r = ref_expand(hw);
                    expq.push_back(mk(32'(hp * 2), r[31:0], 1'b1, r[32]));
                    hp += 1;
                end else begin
                    if (hp + 1 >= endhw) break;
                    expq.push_back(mk(32'(hp * 2), {mem[hp + 1], hw},
                                      1'b0, 1'b0));
                    hp += 2;
                end
            end
            run(3000, $urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
